mb8_arb: RTL and testbench
==========================

Name: mb8_arb

Overview:
- Arbiter and sequencer for the single shared 8-bit spram port (mb8 memory bus).
- Masters: finder, atoier, eforth, comma, and any later bus user.
- Replaces ad-hoc per-state bus muxing in the outer interpreter. Each master requests, is granted exclusive ownership, drives the port, and receives a read-data-valid pulse tagged to it.
- Round-robin arbitration with a fairness quantum, a lock for multi-byte bursts, and one quiet turnaround cycle between owners.

Parameters:
- N, 4, number of requesting masters (2..8).
- ASZ, 17, memory address width.
- MSZ, 8, memory data width.
- QMAX, 8, quantum: cycles an unlocked owner may keep the bus while others wait (1..255).
- RD_LAT, 1, spram read latency in cycles (1..3).
- WD_MAX, 1024, watchdog limit on locked ownership (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (0 = reset).
- req  in  N  per-master bus request; held while the master wants the bus.
- lock  in  N  per-master burst lock; suppresses quantum preemption.
- we  in  N  per-master write enable.
- ai  in  N*ASZ  per-master address, packed, master i at [i*ASZ +: ASZ].
- vi  in  N*MSZ  per-master write data, packed.
- gnt  out  N  one-hot grant.
- rdv  out  N  read data valid pulse to the master that issued the read.
- vo  out  MSZ  read data; combinational pass-through of mem_vo.
- mem_we  out  1  spram write enable.
- mem_ai  out  ASZ  spram address.
- mem_vi  out  MSZ  spram write data.
- mem_vo  in  MSZ  spram read data.
- wd_err  out  1  sticky watchdog error; tied to 0 without the optional feature.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; gnt=0; mem_we=0, mem_ai=0, mem_vi=0; rdv=0; read pipeline cleared.
  - ptr=N-1, so master 0 wins first; qcnt=0; wd_err=0.
  - Takes effect immediately, including mid-burst or mid-write.
- State IDLE:
  - gnt=0, mem_we=0.
  - If any req is high: winner = first requester scanning ptr+1, ptr+2, ... modulo N. Register owner=winner, ptr=winner, qcnt=0, go to OWN.
  - Latency: req high at edge t gives gnt high after edge t+1.
- State OWN:
  - gnt[owner]=1.
  - mem_ai=ai[owner] and mem_vi=vi[owner] combinationally. mem_we=we[owner]&req[owner].
  - An access occurs on every cycle with gnt[owner]&req[owner]. Non-owner inputs are ignored.
  - qcnt increments per cycle and saturates at QMAX.
  - Go to SWITCH when either:
    - req[owner]=0, or
    - qcnt==QMAX and lock[owner]=0 and some other req is high.
  - If only the owner requests, it keeps the bus indefinitely (parking); qcnt stays saturated.
- State SWITCH (exactly one cycle):
  - gnt=0, mem_we=0, mem_ai=0 (quiet bus).
  - Next state and winner are picked exactly as in IDLE, so back-to-back ownership is possible but always separated by SWITCH.
- Read pipeline:
  - Each OWN cycle with req[owner]&!we[owner] pushes {valid, owner} into an RD_LAT-deep shift register.
  - rdv[tag] pulses one cycle when the entry exits, aligned with valid mem_vo.
  - In-flight reads complete through SWITCH and the next grant, and go to the original issuer.
- Simultaneous events:
  - Owner dropping req and a preemption condition in the same cycle: treat as a single SWITCH.
  - lock asserted in the same cycle qcnt reaches QMAX: lock wins, no preemption.
  - lock without req has no effect.
- Invariants:
  - gnt is one-hot or zero.
  - mem_we=0 whenever gnt=0.

Optional Feature:
- Macro: MB8_ARB_WDOG_EN.
- Defined:
  - A wcnt counter runs while OWN and lock[owner]=1.
  - At WD_MAX the arbiter forces the SWITCH transition regardless of lock and sets wd_err=1.
  - wd_err clears only on reset.
  - wcnt clears on every new grant.
- Undefined: no counter, lock is honoured indefinitely, wd_err tied to 0.

Decomposition:
- Package mb8_arb_pkg:
  - arb_st_e enum {IDLE, OWN, SWITCH}.
  - rd_tag_t struct {valid, owner[$clog2(N)-1:0]}.
  - Quantum/watchdog width constants.
- Sub-module rr_pick:
  - Purely combinational round-robin picker.
  - Inputs: req[N], ptr. Outputs: any, winner index.
  - Instantiated once and shared by the IDLE and SWITCH paths.

Test Plan:
1. Single request: IDLE, req=0100, ai[2]=0x00100, we[2]=0 -> gnt=0100 one cycle later; mem_ai=0x00100; with RD_LAT=1 and mem_vo=0x5A, rdv[2] pulses the following cycle and vo=0x5A.
2. Fairness: req[0]=req[1]=1 held, QMAX=4, no lock -> gnt0 for 4 cycles, 1 SWITCH cycle, gnt1 for 4 cycles, SWITCH, gnt0 again; mem_we never high during SWITCH.
3. Lock: req[3]=lock[3]=1 with req[0] pending, QMAX=4 -> gnt3 held past 4 cycles until lock[3] falls, then SWITCH, then gnt0.
4. Read across switch: master 1 issues a read to 0x00010 on its last owned cycle, then drops req, RD_LAT=2 -> rdv[1] pulses 2 cycles later, during SWITCH/next grant; the new owner receives no rdv for it.
5. Reset mid-write: master 0 writing 0xAB to 0x00020, rst falls between edges -> gnt=0 and mem_we=0 immediately; after release, master 0 regrants first.
6. MB8_ARB_WDOG_EN, WD_MAX=16: lock[2] held for 20 cycles with req[1] pending -> forced SWITCH after cycle 16, wd_err=1 sticky, gnt1 follows.

Source files
------------

// File: rtl/mb8_arb_pkg.sv
// mb8_arb_pkg: shared types and widths for the mb8 bus arbiter.
//   arb_st_e  : arbiter FSM state (IDLE, OWN, SWITCH)
//   rd_tag_t  : one read-pipeline entry {valid, owner}
//   TAG_W     : owner tag width, wide enough for the largest legal N (8)
//   QCNT_W    : quantum counter width (QMAX up to 255)
//   WCNT_W    : watchdog counter width (MB8_ARB_WDOG_EN builds only)
package mb8_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OWN    = 2'd1,
    SWITCH = 2'd2
  } arb_st_e;

  // Sized for the maximum master count so the struct is fixed-width
  // regardless of how the arbiter is parameterised.
  localparam int TAG_W  = 3;
  localparam int QCNT_W = 8;
  localparam int WCNT_W = 16;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] owner;
  } rd_tag_t;

endpackage

// File: rtl/mb8_arb_rr_pick.sv
// rr_pick: combinational round-robin picker.
//   req    : per-master request vector
//   ptr    : index of the last winner; the scan starts at ptr+1
//   any    : at least one request is high
//   winner : first requester at ptr+1, ptr+2, ... modulo N
module rr_pick #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic                 any,
  output logic [$clog2(N)-1:0] winner
);

  localparam int IW = $clog2(N);

  logic found;

  always_comb begin
    any    = |req;
    winner = '0;
    found  = 1'b0;
    // Offsets 1..N so the previous winner is considered last.
    for (int i = 1; i <= N; i++) begin
      if (!found && req[(int'(ptr) + i) % N]) begin
        winner = IW'((int'(ptr) + i) % N);
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mb8_arb.sv
// mb8_arb: arbiter/sequencer for the single shared 8-bit spram port.
// Round-robin grant with a fairness quantum, per-master burst lock and
// one quiet SWITCH cycle between owners.
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   req[N]          bus request, held while the master wants the bus
//   lock[N]         burst lock, suppresses quantum preemption
//   we[N]           write enable
//   ai[N*ASZ]       address, master i at [i*ASZ +: ASZ]
//   vi[N*MSZ]       write data, master i at [i*MSZ +: MSZ]
//   gnt[N]          one-hot grant (registered)
//   rdv[N]          read-data-valid pulse to the master that issued the read
//   vo[MSZ]         read data, pass-through of mem_vo
//   mem_we/ai/vi    spram write enable / address / write data
//   mem_vo          spram read data
//   wd_err          sticky watchdog error
//   state           debug view of the arbiter FSM
//
// Optional feature: define MB8_ARB_WDOG_EN to add a watchdog that forces a
// locked owner off the bus after WD_MAX locked cycles and sets wd_err.
//
// Handshake: a master raises req and holds it; it owns the bus on every
// cycle gnt is high, and each cycle with gnt & req is exactly one access.
// Dropping req releases the bus; gnt falls on the following edge.
module mb8_arb
  import mb8_arb_pkg::*;
#(
  parameter int N      = 4,
  parameter int ASZ    = 17,
  parameter int MSZ    = 8,
  parameter int QMAX   = 8,
  parameter int RD_LAT = 1,
  parameter int WD_MAX = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req,
  input  logic [N-1:0]     lock,
  input  logic [N-1:0]     we,
  input  logic [N*ASZ-1:0] ai,
  input  logic [N*MSZ-1:0] vi,
  output logic [N-1:0]     gnt,
  output logic [N-1:0]     rdv,
  output logic [MSZ-1:0]   vo,
  output logic             mem_we,
  output logic [ASZ-1:0]   mem_ai,
  output logic [MSZ-1:0]   mem_vi,
  input  logic [MSZ-1:0]   mem_vo,
  output logic             wd_err,
  output arb_st_e          state
);

  localparam int IW = $clog2(N);

  // Elaboration-time guards on the legal parameter ranges.
  if (N < 2 || N > 8) begin : g_bad_n
    $error("mb8_arb: N must be 2..8");
  end
  if (QMAX < 1 || QMAX > 255) begin : g_bad_qmax
    $error("mb8_arb: QMAX must be 1..255");
  end
  if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
    $error("mb8_arb: RD_LAT must be 1..3");
  end
  if (WD_MAX < 1) begin : g_bad_wd_max
    $error("mb8_arb: WD_MAX must be at least 1");
  end

  arb_st_e           st;
  logic [IW-1:0]     owner;
  logic [IW-1:0]     ptr;
  logic [QCNT_W-1:0] qcnt;

  logic              any;
  logic [IW-1:0]     winner;

  logic              own_active;
  logic              own_req;
  logic              own_we;
  logic              own_lock;
  logic [N-1:0]      own_mask;
  logic              others;
  logic              q_expire;
  logic              preempt;
  logic              wd_hit;
  logic              drop_bus;
  logic              grant_now;
  logic              rd_push;

  rr_pick #(.N(N)) u_pick (
    .req    (req),
    .ptr    (ptr),
    .any    (any),
    .winner (winner)
  );

  assign own_active = (st == OWN);
  assign own_req    = req[owner];
  assign own_we     = we[owner];
  assign own_lock   = lock[owner];
  assign own_mask   = N'(1) << owner;
  assign others     = |(req & ~own_mask);
  assign grant_now  = (st != OWN) && any;

  // qcnt holds the number of owned cycles before this one, so the quantum
  // is spent on the QMAX-th owned cycle and the owner gets exactly QMAX.
  assign q_expire = (int'(qcnt) + 1 >= QMAX);
  assign preempt  = q_expire && !own_lock && others;
  assign drop_bus = !own_req || preempt || wd_hit;

  // Bus drive: the owner's signals pass straight through; quiet otherwise.
  assign mem_ai  = own_active ? ai[int'(owner)*ASZ +: ASZ] : '0;
  assign mem_vi  = own_active ? vi[int'(owner)*MSZ +: MSZ] : '0;
  assign mem_we  = own_active && own_req && own_we;
  assign rd_push = own_active && own_req && !own_we;
  assign vo      = mem_vo;
  assign state   = st;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st    <= IDLE;
      owner <= '0;
      ptr   <= IW'(N - 1);
      qcnt  <= '0;
      gnt   <= '0;
    end else begin
      case (st)
        IDLE, SWITCH: begin
          if (any) begin
            st    <= OWN;
            owner <= winner;
            ptr   <= winner;
            qcnt  <= '0;
            gnt   <= N'(1) << winner;
          end else begin
            st    <= IDLE;
            gnt   <= '0;
          end
        end
        OWN: begin
          if (int'(qcnt) < QMAX) qcnt <= qcnt + QCNT_W'(1);
          if (drop_bus) begin
            st  <= SWITCH;
            gnt <= '0;
          end
        end
        default: begin
          st  <= IDLE;
          gnt <= '0;
        end
      endcase
    end
  end

  // Read pipeline: each entry carries the issuer so the rdv pulse reaches
  // the original master even after ownership has moved on.
  rd_tag_t rd_pipe [RD_LAT];
  rd_tag_t rd_out;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
    end else begin
      rd_pipe[0] <= '{valid: rd_push, owner: TAG_W'(owner)};
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
  end

  assign rd_out = rd_pipe[RD_LAT-1];

  always_comb begin
    rdv = '0;
    for (int i = 0; i < N; i++)
      rdv[i] = rd_out.valid && (rd_out.owner == TAG_W'(i));
  end

`ifdef MB8_ARB_WDOG_EN
  logic [WCNT_W-1:0] wcnt;

  // Counts owned cycles with lock held; the WD_MAX-th such cycle is the
  // last one before the bus is taken away regardless of lock.
  assign wd_hit = own_active && own_req && own_lock &&
                  (int'(wcnt) + 1 >= WD_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wcnt   <= '0;
      wd_err <= 1'b0;
    end else begin
      if (grant_now)
        wcnt <= '0;
      else if (own_active && own_req && own_lock && (int'(wcnt) < WD_MAX))
        wcnt <= wcnt + WCNT_W'(1);
      if (wd_hit) wd_err <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
  assign wd_err = 1'b0;
`endif

endmodule

// File: tb/tb_mb8_arb.sv
// tb_mb8_arb: self-checking bench for mb8_arb. A spram model with RD_LAT
// read latency sits on the memory port; a transaction-level reference
// (current owner, cycles owned, pending reads in a queue, shadow memory)
// predicts every bus output each cycle. Honours MB8_ARB_WDOG_EN.
module tb_mb8_arb;
  import mb8_arb_pkg::*;

  localparam int N      = 4;
  localparam int ASZ    = 17;
  localparam int MSZ    = 8;
  localparam int QMAX   = 4;
  localparam int RD_LAT = 2;
  localparam int WD_MAX = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N-1:0]     lock = '0;
  logic [N-1:0]     we = '0;
  logic [N*ASZ-1:0] ai = '0;
  logic [N*MSZ-1:0] vi = '0;
  logic [N-1:0]     gnt;
  logic [N-1:0]     rdv;
  logic [MSZ-1:0]   vo;
  logic             mem_we;
  logic [ASZ-1:0]   mem_ai;
  logic [MSZ-1:0]   mem_vi;
  logic [MSZ-1:0]   mem_vo;
  logic             wd_err;
  arb_st_e          state;

  int checks   = 0;
  int failures = 0;

  mb8_arb #(
    .N(N), .ASZ(ASZ), .MSZ(MSZ), .QMAX(QMAX), .RD_LAT(RD_LAT), .WD_MAX(WD_MAX)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .lock(lock), .we(we), .ai(ai), .vi(vi),
    .gnt(gnt), .rdv(rdv), .vo(vo), .mem_we(mem_we), .mem_ai(mem_ai),
    .mem_vi(mem_vi), .mem_vo(mem_vo), .wd_err(wd_err), .state(state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  // ---------------- spram model ----------------
  logic [7:0] env_mem [256];
  logic [7:0] vo_pipe [RD_LAT];
  logic       mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) env_mem[i] <= 8'(i + 'h5A);
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      env_mem[mem_ai[7:0]] <= mem_vi;
    end
    vo_pipe[0] <= env_mem[mem_ai[7:0]];
    for (int i = 1; i < RD_LAT; i++) vo_pipe[i] <= vo_pipe[i-1];
  end
  assign mem_vo = vo_pipe[RD_LAT-1];

  // ---------------- reference model ----------------
  typedef struct {
    int         due;
    int         m;
    logic [7:0] d;
  } rd_rec_t;

  rd_rec_t    rq[$];
  logic [7:0] exp_mem [256];
  int         m_owner;   // -1 when nobody owns the bus
  int         m_ptr;
  int         m_held;
  int         m_locked;
  bit         m_wd;
  int         cyc;

  task automatic model_reset();
    m_owner  = -1;
    m_ptr    = N - 1;
    m_held   = 0;
    m_locked = 0;
    m_wd     = 1'b0;
    rq.delete();
  endtask

  task automatic model_advance();
    int  o;
    bit  rel;
    bit  other;
    bit  found;
    logic [7:0] addr;
    while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
    if (m_owner < 0) begin
      found = 1'b0;
      for (int k = 1; k <= N; k++) begin
        if (!found && req[(m_ptr + k) % N]) begin
          m_owner = (m_ptr + k) % N;
          found   = 1'b1;
        end
      end
      if (found) begin
        m_ptr    = m_owner;
        m_held   = 0;
        m_locked = 0;
      end
    end else begin
      o = m_owner;
      if (req[o]) begin
        addr = ai[o*ASZ +: 8];
        if (we[o]) exp_mem[addr] = vi[o*MSZ +: MSZ];
        else rq.push_back('{due: cyc + RD_LAT, m: o, d: exp_mem[addr]});
      end
      m_held++;
      other = 1'b0;
      for (int k = 0; k < N; k++) if (k != o && req[k]) other = 1'b1;
      rel = !req[o] || (m_held >= QMAX && !lock[o] && other);
`ifdef MB8_ARB_WDOG_EN
      if (req[o] && lock[o]) begin
        m_locked++;
        if (m_locked >= WD_MAX) begin
          rel  = 1'b1;
          m_wd = 1'b1;
        end
      end
`endif
      if (rel) m_owner = -1;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: called at posedge+1 with inputs already driven.
  task automatic do_cycle();
    logic [N-1:0]   e_gnt;
    logic [N-1:0]   e_rdv;
    logic [ASZ-1:0] e_ai;
    logic [MSZ-1:0] e_vi;
    logic           e_we;
    logic [7:0]     e_vo;
    bit             have_rd;
    e_gnt = '0; e_rdv = '0; e_ai = '0; e_vi = '0; e_we = 1'b0;
    e_vo = '0; have_rd = 1'b0;
    if (m_owner >= 0) begin
      e_gnt[m_owner] = 1'b1;
      e_ai = ai[m_owner*ASZ +: ASZ];
      e_vi = vi[m_owner*MSZ +: MSZ];
      e_we = we[m_owner] & req[m_owner];
    end
    foreach (rq[k]) begin
      if (rq[k].due == cyc) begin
        e_rdv[rq[k].m] = 1'b1;
        e_vo    = rq[k].d;
        have_rd = 1'b1;
      end
    end
    @(negedge clk);
    chk("gnt", 32'(gnt), 32'(e_gnt));
    chk("mem_we", 32'(mem_we), 32'(e_we));
    chk("mem_ai", 32'(mem_ai), 32'(e_ai));
    if (m_owner >= 0) chk("mem_vi", 32'(mem_vi), 32'(e_vi));
    chk("rdv", 32'(rdv), 32'(e_rdv));
    if (have_rd) chk("vo", 32'(vo), 32'(e_vo));
    chk("wd_err", 32'(wd_err), 32'(m_wd));
    model_advance();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Asynchronous reset dropped mid-cycle; outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_ai", 32'(mem_ai), 32'h0);
    chk("rst_rdv", 32'(rdv), 32'h0);
    chk("rst_wd_err", 32'(wd_err), 32'h0);
    chk("rst_state", 32'(state), 32'(IDLE));
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    cyc += 2;
  endtask

  task automatic set_m(input int i, input bit r, input bit l, input bit w,
                       input logic [ASZ-1:0] a, input logic [MSZ-1:0] d);
    req[i] = r; lock[i] = l; we[i] = w;
    ai[i*ASZ +: ASZ] = a;
    vi[i*MSZ +: MSZ] = d;
  endtask

  task automatic clr_all();
    req = '0; lock = '0; we = '0; ai = '0; vi = '0;
  endtask

  task automatic wait_gnt(input int m, input int budget);
    int n;
    n = 0;
    while (gnt[m] !== 1'b1 && n < budget) begin
      do_cycle();
      n++;
    end
    chk($sformatf("wait_gnt%0d", m), 32'(gnt[m]), 32'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i + 'h5A);
    model_reset();
    cyc = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("init_gnt", 32'(gnt), 32'h0);
    chk("init_mem_we", 32'(mem_we), 32'h0);
    chk("init_mem_ai", 32'(mem_ai), 32'h0);
    chk("init_mem_vi", 32'(mem_vi), 32'h0);
    chk("init_rdv", 32'(rdv), 32'h0);
    chk("init_wd_err", 32'(wd_err), 32'h0);
    chk("init_state", 32'(state), 32'(IDLE));
    @(posedge clk);
    #1 rst = 1'b1;

    // Single read by master 2 at 0x00100 (memory there holds 0x5A).
    set_m(2, 1, 0, 0, 17'h00100, 8'h00);
    do_cycle();
    do_cycle();
    req[2] = 1'b0;
    repeat (5) do_cycle();

    // Fairness between masters 0 and 1 with writes from master 0.
    set_m(0, 1, 0, 1, 17'h00040, 8'h3C);
    set_m(1, 1, 0, 0, 17'h00040, 8'h00);
    repeat (16) do_cycle();
    clr_all();
    repeat (3) do_cycle();

    // Lock: master 3 locked while master 0 waits.
    set_m(3, 1, 1, 0, 17'h00033, 8'h00);
    set_m(0, 1, 0, 0, 17'h00011, 8'h00);
    wait_gnt(3, 20);
    repeat (9) do_cycle();
    lock[3] = 1'b0;
    repeat (8) do_cycle();
    clr_all();
    repeat (3) do_cycle();

    // Read issued on master 1's last owned cycle, completing across SWITCH.
    set_m(1, 1, 0, 0, 17'h00010, 8'h00);
    set_m(2, 1, 0, 0, 17'h00077, 8'h00);
    wait_gnt(1, 20);
    do_cycle();
    req[1] = 1'b0;
    repeat (6) do_cycle();
    clr_all();
    repeat (3) do_cycle();

    // Reset in the middle of a write; master 0 regrants first afterwards.
    set_m(0, 1, 0, 1, 17'h00020, 8'hAB);
    wait_gnt(0, 20);
    do_reset();
    set_m(1, 1, 0, 0, 17'h00021, 8'h00);
    set_m(2, 1, 0, 0, 17'h00022, 8'h00);
    set_m(3, 1, 0, 0, 17'h00023, 8'h00);
    repeat (6) do_cycle();
    clr_all();
    repeat (3) do_cycle();

    // Long lock by master 2 with master 1 pending (watchdog case).
    set_m(2, 1, 1, 1, 17'h00050, 8'h77);
    set_m(1, 1, 0, 0, 17'h00050, 8'h00);
    wait_gnt(2, 20);
    repeat (20) do_cycle();
    clr_all();
    repeat (4) do_cycle();

    // Randomised traffic with occasional resets.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
        if ($urandom_range(0, 5) == 0) lock[i] = ($urandom_range(0, 2) == 0);
        we[i] = ($urandom_range(0, 2) == 0);
        ai[i*ASZ +: ASZ] = ASZ'($urandom_range(0, 'h1FFFF));
        vi[i*MSZ +: MSZ] = MSZ'($urandom);
      end
      if ($urandom_range(0, 399) == 0) do_reset();
      else do_cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
